usb_endpoint_ctrl: RTL and testbench
====================================

# usb_endpoint_ctrl

Protocol controller for the bulk endpoint: it sequences the USB receiver, the USB transmitter and the shared 64-byte data buffer. It watches the decoded packet status from `usb_rx` and decides how to respond to each transaction. For OUT transactions it gates stores into the buffer and answers ACK/NAK. For IN transactions it commands `usb_tx` to send DATA or NAK, then waits for the host handshake. It sits between `usb_rx`/`usb_tx`/`data_buffer` and the AHB-Lite slave.

## Interface
- `MAX_PACKET`, 64: buffer capacity in bytes.
- `TIMEOUT_CYCLES`, 144: host-response timeout in clocks (18 bit times × 8 clk/bit).
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `rx_packet`  in  3  status from `usb_rx` (`rx_packet_t`).
- `store_rx_packet_data`  in  1  one-cycle byte-store strobe from `usb_rx`.
- `buffer_occupancy`  in  7  bytes currently in buffer, 0..64.
- `tx_packet_data_size`  in  7  bytes loaded by AHB side for IN.
- `tx_done`  in  1  one-cycle pulse from `usb_tx` at end of its EOP.
- `tx_packet`  out  3  packet type for `usb_tx` (`tx_packet_t`), stable while `d_mode`=1.
- `tx_start`  out  1  one-cycle pulse that launches `usb_tx`.
- `d_mode`  out  1  1 = transmitter owns bus.
- `store_enable`  out  1  gates `store_rx_packet_data` into buffer.
- `clear`  out  1  one-cycle buffer flush.
- `rx_data_ready`  out  1  level; OUT data accepted and waiting for AHB.
- `rx_error`, `tx_error`  out  1 each  one-cycle error pulses.

## Operation
- `rx_packet_t`: NONE=0, IN=1, OUT=2, DATA=3, ERROR=4, DONE=5, ACK=6, NAK=7.
- `tx_packet_t`: NONE=0, DATA=1, ACK=2, NAK=3.
- An rx event is a cycle where `rx_packet` differs from its registered previous value. A held level is never re-acted on.
- States and transitions:
  - IDLE: event OUT → OUT_TOKEN; event IN → IN_TOKEN.
  - OUT_TOKEN: DONE → OUT_WAIT. Latch `accept` = (`buffer_occupancy`==0). ERROR → IDLE.
  - OUT_WAIT: DATA → OUT_DATA, with `store_enable`=`accept`. Timeout → IDLE + `rx_error`.
  - OUT_DATA: DONE → SEND, with ACK if `accept`, else NAK. On ACK, set `rx_data_ready`. ERROR → IDLE + `rx_error`, plus `clear` if `accept`.
  - IN_TOKEN: DONE → SEND, with DATA if `tx_packet_data_size`≠0, else NAK. ERROR → IDLE.
  - SEND: `tx_start` pulse, `d_mode`=1. On `tx_done`: DATA → IN_WAIT, otherwise → IDLE.
  - IN_WAIT: ACK → IN_ACK. NAK, ERROR or timeout → IDLE + `tx_error`; data is retained for retry.
  - IN_ACK: DONE → IDLE + `clear`. ERROR → IDLE + `tx_error`.
- `rx_data_ready` clears when `buffer_occupancy` reads 0 in IDLE.
- Timeout counter:
  - Cleared on entry to OUT_WAIT or IN_WAIT.
  - Increments each cycle in those states.
  - Fires when the count equals `TIMEOUT_CYCLES`-1.
  - Simultaneous rx event and timeout: the rx event wins.
- Any event not listed for the current state is ignored, except an rx event in SEND, which is dropped.

## Timing
- All outputs are registered (Moore).
- Reset values: state IDLE; every output 0; `tx_packet`=NONE.
- Decision latency: event sampled at edge k → new state and outputs visible after edge k+1.
- `tx_start` is high for exactly the first cycle of SEND. `d_mode` and `tx_packet` go high/valid in that same cycle.
- `tx_done` sampled at edge m → `d_mode`=0 and `tx_packet`=NONE after edge m.
- `store_enable` deasserts the cycle after DONE or ERROR is detected in OUT_DATA.
- `clear`, `rx_error` and `tx_error` are single-cycle pulses, each issued in the transition cycle.
- Reset mid-operation: immediate return to IDLE, all outputs zero, timeout counter zero.

## Structure
- Package `usb_pkg`: `rx_packet_t`, `tx_packet_t`, `MAX_PACKET_SIZE`=64, the state enum. The package is shared with `usb_rx`, `usb_tx` and `data_buffer`.
- Sub-module `usb_timeout_timer`: clear/enable counter with a terminal-count pulse, parameterised by `TIMEOUT_CYCLES`.
- Rx edge-detect register, FSM and output registers stay in this module.

## Test plan
- OUT accepted: occupancy 0; OUT, DONE, DATA, 4 store strobes, DONE.
  - `store_enable` is high during the 4 strobes.
  - `tx_start` pulses with `tx_packet`=ACK.
  - `tx_done` → `d_mode`=0 and `rx_data_ready`=1.
- OUT refused: occupancy 10; same OUT sequence → `store_enable` stays 0 throughout; NAK is sent; `rx_data_ready` stays 0.
- IN with data: size 8; IN, DONE → DATA sent; `tx_done`; ACK, DONE → `clear` pulses exactly once.
- IN host timeout: size 8; IN, DONE; `tx_done`; no host response.
  - `tx_error` pulses 144 cycles after IN_WAIT entry.
  - No `clear`.
- OUT with rx ERROR mid-data → `rx_error` pulse, `clear` pulse, no `tx_start`.
- `n_rst` asserted during SEND → `d_mode` and `tx_start` drop immediately; the next IN, DONE is handled normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB bulk-endpoint types: decoded rx status, tx packet commands and controller states.
package usb_pkg;

    localparam int unsigned MAX_PACKET_SIZE = 64;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_IN    = 3'd1,
        RX_OUT   = 3'd2,
        RX_DATA  = 3'd3,
        RX_ERROR = 3'd4,
        RX_DONE  = 3'd5,
        RX_ACK   = 3'd6,
        RX_NAK   = 3'd7
    } rx_packet_t;

    typedef enum logic [2:0] {
        TX_NONE = 3'd0,
        TX_DATA = 3'd1,
        TX_ACK  = 3'd2,
        TX_NAK  = 3'd3
    } tx_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT_TOKEN,
        ST_OUT_WAIT,
        ST_OUT_DATA,
        ST_IN_TOKEN,
        ST_SEND,
        ST_IN_WAIT,
        ST_IN_ACK
    } ep_state_t;

endpackage

// File: rtl/usb_timeout_timer.sv
// Host-response timer: counts while enabled, held at zero while cleared,
// and flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
module usb_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 144
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate at the terminal value so a missed expiry cannot wrap into a late one.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != TERMINAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == TERMINAL);

endmodule

// File: rtl/usb_endpoint_ctrl.sv
// Bulk-endpoint protocol controller: reacts to usb_rx status changes, gates buffer
// stores, and sequences usb_tx responses and the host handshake.
module usb_endpoint_ctrl
    import usb_pkg::*;
#(
    parameter  int unsigned MAX_PACKET     = MAX_PACKET_SIZE,
    parameter  int unsigned TIMEOUT_CYCLES = 144,
    localparam int unsigned OCC_W          = $clog2(MAX_PACKET + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  rx_packet_t       rx_packet,
    input  logic             store_rx_packet_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [OCC_W-1:0] tx_packet_data_size,
    input  logic             tx_done,
    output tx_packet_t       tx_packet,
    output logic             tx_start,
    output logic             d_mode,
    output logic             store_enable,
    output logic             clear,
    output logic             rx_data_ready,
    output logic             rx_error,
    output logic             tx_error
);

    ep_state_t  state_q, state_d;
    rx_packet_t rx_q, rx_prev_q;
    tx_packet_t tx_packet_q, tx_packet_d;
    logic       tx_start_q, tx_start_d;
    logic       d_mode_q, d_mode_d;
    logic       store_enable_q, store_enable_d;
    logic       clear_q, clear_d;
    logic       rx_data_ready_q, rx_data_ready_d;
    logic       rx_error_q, rx_error_d;
    logic       tx_error_q, tx_error_d;
    logic       accept_q, accept_d;

    logic rx_event;
    logic waiting;
    logic timed_out;
    logic unused_store_strobe;

    // The byte strobe goes straight to the buffer; this block only supplies its gate.
    assign unused_store_strobe = store_rx_packet_data;

    assign rx_event = (rx_q != rx_prev_q);
    assign waiting  = (state_q == ST_OUT_WAIT) || (state_q == ST_IN_WAIT);

    usb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (!waiting),
        .enable (waiting),
        .expired(timed_out)
    );

    always_comb begin
        state_d         = state_q;
        tx_packet_d     = tx_packet_q;
        tx_start_d      = 1'b0;
        d_mode_d        = d_mode_q;
        store_enable_d  = store_enable_q;
        clear_d         = 1'b0;
        rx_data_ready_d = rx_data_ready_q;
        rx_error_d      = 1'b0;
        tx_error_d      = 1'b0;
        accept_d        = accept_q;

        unique case (state_q)
            ST_IDLE: begin
                if (buffer_occupancy == '0) begin
                    rx_data_ready_d = 1'b0;
                end
                if (rx_event && (rx_q == RX_OUT)) begin
                    state_d = ST_OUT_TOKEN;
                end else if (rx_event && (rx_q == RX_IN)) begin
                    state_d = ST_IN_TOKEN;
                end
            end
            ST_OUT_TOKEN: begin
                if (rx_event && (rx_q == RX_DONE)) begin
                    state_d  = ST_OUT_WAIT;
                    accept_d = (buffer_occupancy == '0);
                end else if (rx_event && (rx_q == RX_ERROR)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT_WAIT: begin
                if (rx_event && (rx_q == RX_DATA)) begin
                    state_d        = ST_OUT_DATA;
                    store_enable_d = accept_q;
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    rx_error_d = 1'b1;
                end
            end
            ST_OUT_DATA: begin
                if (rx_event && (rx_q == RX_DONE)) begin
                    state_d         = ST_SEND;
                    store_enable_d  = 1'b0;
                    tx_packet_d     = accept_q ? TX_ACK : TX_NAK;
                    tx_start_d      = 1'b1;
                    d_mode_d        = 1'b1;
                    rx_data_ready_d = rx_data_ready_q | accept_q;
                end else if (rx_event && (rx_q == RX_ERROR)) begin
                    state_d        = ST_IDLE;
                    store_enable_d = 1'b0;
                    rx_error_d     = 1'b1;
                    clear_d        = accept_q;
                end
            end
            ST_IN_TOKEN: begin
                if (rx_event && (rx_q == RX_DONE)) begin
                    state_d     = ST_SEND;
                    tx_packet_d = (tx_packet_data_size != '0) ? TX_DATA : TX_NAK;
                    tx_start_d  = 1'b1;
                    d_mode_d    = 1'b1;
                end else if (rx_event && (rx_q == RX_ERROR)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    state_d     = (tx_packet_q == TX_DATA) ? ST_IN_WAIT : ST_IDLE;
                    tx_packet_d = TX_NONE;
                    d_mode_d    = 1'b0;
                end
            end
            ST_IN_WAIT: begin
                // A recognised handshake beats a coincident timeout; the buffer is kept for a retry.
                if (rx_event && (rx_q == RX_ACK)) begin
                    state_d = ST_IN_ACK;
                end else if (rx_event && ((rx_q == RX_NAK) || (rx_q == RX_ERROR))) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end
            end
            ST_IN_ACK: begin
                if (rx_event && (rx_q == RX_DONE)) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end else if (rx_event && (rx_q == RX_ERROR)) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            rx_q            <= RX_NONE;
            rx_prev_q       <= RX_NONE;
            tx_packet_q     <= TX_NONE;
            tx_start_q      <= 1'b0;
            d_mode_q        <= 1'b0;
            store_enable_q  <= 1'b0;
            clear_q         <= 1'b0;
            rx_data_ready_q <= 1'b0;
            rx_error_q      <= 1'b0;
            tx_error_q      <= 1'b0;
            accept_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_q            <= rx_packet;
            rx_prev_q       <= rx_q;
            tx_packet_q     <= tx_packet_d;
            tx_start_q      <= tx_start_d;
            d_mode_q        <= d_mode_d;
            store_enable_q  <= store_enable_d;
            clear_q         <= clear_d;
            rx_data_ready_q <= rx_data_ready_d;
            rx_error_q      <= rx_error_d;
            tx_error_q      <= tx_error_d;
            accept_q        <= accept_d;
        end
    end

    assign tx_packet     = tx_packet_q;
    assign tx_start      = tx_start_q;
    assign d_mode        = d_mode_q;
    assign store_enable  = store_enable_q;
    assign clear         = clear_q;
    assign rx_data_ready = rx_data_ready_q;
    assign rx_error      = rx_error_q;
    assign tx_error      = tx_error_q;

endmodule

// File: tb/tb_usb_endpoint_ctrl.sv
// Directed bench for usb_endpoint_ctrl: OUT accept/refuse, IN data/empty/timeout,
// rx error mid-data and reset during SEND.
module tb_usb_endpoint_ctrl;
    import usb_pkg::*;

    logic       clk;
    logic       n_rst;
    rx_packet_t rx_packet;
    logic       store_rx_packet_data;
    logic [6:0] buffer_occupancy;
    logic [6:0] tx_packet_data_size;
    logic       tx_done;
    tx_packet_t tx_packet;
    logic       tx_start;
    logic       d_mode;
    logic       store_enable;
    logic       clear;
    logic       rx_data_ready;
    logic       rx_error;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    int         tx_start_cnt = 0;
    int         clear_cnt    = 0;
    int         rx_error_cnt = 0;
    int         tx_error_cnt = 0;
    int         store_en_cnt = 0;
    tx_packet_t last_tx_pkt  = TX_NONE;

    usb_endpoint_ctrl dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .rx_packet           (rx_packet),
        .store_rx_packet_data(store_rx_packet_data),
        .buffer_occupancy    (buffer_occupancy),
        .tx_packet_data_size (tx_packet_data_size),
        .tx_done             (tx_done),
        .tx_packet           (tx_packet),
        .tx_start            (tx_start),
        .d_mode              (d_mode),
        .store_enable        (store_enable),
        .clear               (clear),
        .rx_data_ready       (rx_data_ready),
        .rx_error            (rx_error),
        .tx_error            (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start) begin
            tx_start_cnt++;
            last_tx_pkt = tx_packet;
        end
        if (clear)        clear_cnt++;
        if (rx_error)     rx_error_cnt++;
        if (tx_error)     tx_error_cnt++;
        if (store_enable) store_en_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input rx_packet_t p);
        rx_packet = p;
        step(3);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(1);
    endtask

    task automatic strobe_bytes(input int n, input logic exp_en);
        for (int i = 0; i < n; i++) begin
            store_rx_packet_data = 1'b1;
            checks++;
            if (store_enable !== exp_en) begin
                errors++;
                $display("[TB] FAIL store_enable_strobe%0d: got %b expected %b", i, store_enable, exp_en);
            end
            step(1);
            store_rx_packet_data = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        step(2);
        checks++;
        if ({tx_start, d_mode, store_enable, clear, rx_data_ready, rx_error, tx_error} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                     {tx_start, d_mode, store_enable, clear, rx_data_ready, rx_error, tx_error});
        end
        checks++;
        if (tx_packet !== TX_NONE) begin
            errors++;
            $display("[TB] FAIL reset_tx_packet: got %0d expected %0d", tx_packet, TX_NONE);
        end
        n_rst = 1'b1;
        step(2);
    endtask

    task automatic test_out_accepted();
        int s0;
        buffer_occupancy = 7'd0;
        s0 = tx_start_cnt;
        send_rx(RX_OUT);
        send_rx(RX_DONE);
        send_rx(RX_DATA);
        strobe_bytes(4, 1'b1);
        buffer_occupancy = 7'd4;
        send_rx(RX_DONE);
        checks++;
        if ((tx_start_cnt - s0) !== 1) begin
            errors++;
            $display("[TB] FAIL out_ack_tx_start_count: got %0d expected 1", tx_start_cnt - s0);
        end
        checks++;
        if (last_tx_pkt !== TX_ACK) begin
            errors++;
            $display("[TB] FAIL out_ack_tx_packet: got %0d expected %0d", last_tx_pkt, TX_ACK);
        end
        checks++;
        if ({d_mode, store_enable} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL out_ack_send_mode: got %b expected 10", {d_mode, store_enable});
        end
        pulse_tx_done();
        checks++;
        if ({d_mode, rx_data_ready} !== 2'b01 || tx_packet !== TX_NONE) begin
            errors++;
            $display("[TB] FAIL out_ack_done: got d_mode=%b rdy=%b pkt=%0d expected d_mode=0 rdy=1 pkt=0",
                     d_mode, rx_data_ready, tx_packet);
        end
        buffer_occupancy = 7'd0;
        step(2);
        checks++;
        if (rx_data_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL out_ack_ready_clear: got %b expected 0", rx_data_ready);
        end
        send_rx(RX_NONE);
    endtask

    task automatic test_out_refused();
        int s0, e0;
        buffer_occupancy = 7'd10;
        s0 = tx_start_cnt;
        e0 = store_en_cnt;
        send_rx(RX_OUT);
        send_rx(RX_DONE);
        send_rx(RX_DATA);
        strobe_bytes(4, 1'b0);
        send_rx(RX_DONE);
        checks++;
        if ((store_en_cnt - e0) !== 0) begin
            errors++;
            $display("[TB] FAIL out_nak_store_cycles: got %0d expected 0", store_en_cnt - e0);
        end
        checks++;
        if ((tx_start_cnt - s0) !== 1 || last_tx_pkt !== TX_NAK) begin
            errors++;
            $display("[TB] FAIL out_nak_sent: got starts=%0d pkt=%0d expected starts=1 pkt=%0d",
                     tx_start_cnt - s0, last_tx_pkt, TX_NAK);
        end
        pulse_tx_done();
        checks++;
        if ({d_mode, rx_data_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL out_nak_done: got %b expected 00", {d_mode, rx_data_ready});
        end
        buffer_occupancy = 7'd0;
        send_rx(RX_NONE);
    endtask

    task automatic test_in_data();
        int s0, c0, t0;
        tx_packet_data_size = 7'd8;
        s0 = tx_start_cnt;
        c0 = clear_cnt;
        t0 = tx_error_cnt;
        send_rx(RX_IN);
        send_rx(RX_DONE);
        checks++;
        if ((tx_start_cnt - s0) !== 1 || tx_packet !== TX_DATA || d_mode !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_data_send: got starts=%0d pkt=%0d d_mode=%b expected 1 %0d 1",
                     tx_start_cnt - s0, tx_packet, d_mode, TX_DATA);
        end
        pulse_tx_done();
        checks++;
        if (d_mode !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_data_d_mode: got %b expected 0", d_mode);
        end
        send_rx(RX_ACK);
        send_rx(RX_DONE);
        checks++;
        if ((clear_cnt - c0) !== 1 || (tx_error_cnt - t0) !== 0) begin
            errors++;
            $display("[TB] FAIL in_data_clear: got clears=%0d tx_err=%0d expected 1 0",
                     clear_cnt - c0, tx_error_cnt - t0);
        end
        send_rx(RX_NONE);
    endtask

    task automatic test_in_empty();
        int s0, t0;
        tx_packet_data_size = 7'd0;
        s0 = tx_start_cnt;
        t0 = tx_error_cnt;
        send_rx(RX_IN);
        send_rx(RX_DONE);
        checks++;
        if ((tx_start_cnt - s0) !== 1 || last_tx_pkt !== TX_NAK) begin
            errors++;
            $display("[TB] FAIL in_empty_nak: got starts=%0d pkt=%0d expected 1 %0d",
                     tx_start_cnt - s0, last_tx_pkt, TX_NAK);
        end
        pulse_tx_done();
        step(200);
        checks++;
        if ((tx_error_cnt - t0) !== 0 || d_mode !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_empty_idle: got tx_err=%0d d_mode=%b expected 0 0",
                     tx_error_cnt - t0, d_mode);
        end
        send_rx(RX_NONE);
    endtask

    task automatic test_in_timeout();
        int c0, t0, n;
        tx_packet_data_size = 7'd8;
        c0 = clear_cnt;
        t0 = tx_error_cnt;
        send_rx(RX_IN);
        send_rx(RX_DONE);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        checks++;
        if (d_mode !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_d_mode: got %b expected 0", d_mode);
        end
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (tx_error) break;
        end
        checks++;
        if (n !== 144) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected 144", n);
        end
        step(2);
        checks++;
        if ((tx_error_cnt - t0) !== 1 || (clear_cnt - c0) !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_pulses: got tx_err=%0d clears=%0d expected 1 0",
                     tx_error_cnt - t0, clear_cnt - c0);
        end
        send_rx(RX_NONE);
    endtask

    task automatic test_out_error();
        int s0, c0, r0;
        buffer_occupancy = 7'd0;
        s0 = tx_start_cnt;
        c0 = clear_cnt;
        r0 = rx_error_cnt;
        send_rx(RX_OUT);
        send_rx(RX_DONE);
        send_rx(RX_DATA);
        strobe_bytes(2, 1'b1);
        send_rx(RX_ERROR);
        checks++;
        if ((rx_error_cnt - r0) !== 1 || (clear_cnt - c0) !== 1) begin
            errors++;
            $display("[TB] FAIL out_err_pulses: got rx_err=%0d clears=%0d expected 1 1",
                     rx_error_cnt - r0, clear_cnt - c0);
        end
        checks++;
        if ((tx_start_cnt - s0) !== 0 || store_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL out_err_no_tx: got starts=%0d store_en=%b expected 0 0",
                     tx_start_cnt - s0, store_enable);
        end
        send_rx(RX_NONE);
    endtask

    task automatic test_reset_in_send();
        int s0, n;
        tx_packet_data_size = 7'd8;
        send_rx(RX_IN);
        rx_packet = RX_DONE;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (tx_start) break;
        end
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_send_reach: got tx_start=%b expected 1", tx_start);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tx_start, d_mode} !== 2'b00 || tx_packet !== TX_NONE) begin
            errors++;
            $display("[TB] FAIL rst_send_drop: got tx_start=%b d_mode=%b pkt=%0d expected 0 0 0",
                     tx_start, d_mode, tx_packet);
        end
        step(1);
        n_rst = 1'b1;
        send_rx(RX_NONE);
        s0 = tx_start_cnt;
        send_rx(RX_IN);
        send_rx(RX_DONE);
        checks++;
        if ((tx_start_cnt - s0) !== 1 || tx_packet !== TX_DATA || d_mode !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_send_retry: got starts=%0d pkt=%0d d_mode=%b expected 1 %0d 1",
                     tx_start_cnt - s0, tx_packet, d_mode, TX_DATA);
        end
        pulse_tx_done();
        send_rx(RX_ACK);
        send_rx(RX_DONE);
        send_rx(RX_NONE);
    endtask

    initial begin
        n_rst                = 1'b0;
        rx_packet            = RX_NONE;
        store_rx_packet_data = 1'b0;
        buffer_occupancy     = 7'd0;
        tx_packet_data_size  = 7'd0;
        tx_done              = 1'b0;
        step(1);
        test_reset();
        test_out_accepted();
        test_out_refused();
        test_in_data();
        test_in_empty();
        test_in_timeout();
        test_out_error();
        test_reset_in_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
